// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/MEM memory-port arbiter: source tags, read strobe, default tag depth.
package mem_port_arbiter_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam logic [3:0]  WSTRB_READ        = 4'b0000;
  localparam int unsigned TAG_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// arb_tag_fifo: 1-bit source-tag FIFO remembering which requester owns each outstanding memory response.
module arb_tag_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = TAG_DEPTH_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] tag_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = tag_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_q[wr_ptr_q] <= push_tag;
    end
  end

  // Power-of-2 depth lets both pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and load/store requesters and routes in-order responses back.
// Optional macro ARB_RR_EN selects round-robin arbitration; default is fixed priority data > inst.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  src_e        gnt_src;
  logic        gnt_any;
  logic        lock_q;
  src_e        lock_src_q;
  logic [3:0]  lock_wstrb_q;
  logic [31:0] lock_addr_q;
  logic [31:0] lock_wdata_q;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_head;
  logic        accept;
  logic        respond;

`ifdef ARB_RR_EN
  src_e        rr_pref_q;
`endif

  always_comb begin
    gnt_any = 1'b0;
    gnt_src = SRC_DATA;
    if (lock_q) begin
      gnt_any = 1'b1;
      gnt_src = lock_src_q;
    end else if (data_req && inst_req) begin
      gnt_any = 1'b1;
`ifdef ARB_RR_EN
      gnt_src = rr_pref_q;
`else
      gnt_src = SRC_DATA;
`endif
    end else if (data_req) begin
      gnt_any = 1'b1;
      gnt_src = SRC_DATA;
    end else if (inst_req) begin
      gnt_any = 1'b1;
      gnt_src = SRC_INST;
    end
  end

  // While locked the payload comes from the latch, so mem_* stays stable even if the requester lets go.
  always_comb begin
    mem_wstrb = WSTRB_READ;
    mem_addr  = inst_addr;
    mem_wdata = '0;
    if (lock_q) begin
      mem_wstrb = lock_wstrb_q;
      mem_addr  = lock_addr_q;
      mem_wdata = lock_wdata_q;
    end else if (gnt_src == SRC_DATA) begin
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  // A lock is only taken while not full and nothing pushes while locked, so !full holds for locked requests.
  assign mem_req      = !reset && gnt_any && !fifo_full;
  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && (gnt_src == SRC_INST);
  assign data_addr_ok = accept && (gnt_src == SRC_DATA);

  assign respond      = !reset && mem_data_ok && !fifo_empty;
  assign inst_data_ok = respond && (fifo_head == SRC_INST);
  assign data_data_ok = respond && (fifo_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_tag (gnt_src),
    .pop      (respond),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q       <= 1'b0;
      lock_src_q   <= SRC_DATA;
      lock_wstrb_q <= WSTRB_READ;
      lock_addr_q  <= '0;
      lock_wdata_q <= '0;
    end else if (mem_req && !mem_addr_ok) begin
      lock_q       <= 1'b1;
      lock_src_q   <= gnt_src;
      lock_wstrb_q <= mem_wstrb;
      lock_addr_q  <= mem_addr;
      lock_wdata_q <= mem_wdata;
    end else if (accept) begin
      lock_q       <= 1'b0;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_pref_q <= SRC_DATA;
    end else if (accept) begin
      rr_pref_q <= (gnt_src == SRC_DATA) ? SRC_INST : SRC_DATA;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus random traffic against a protocol-level model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned DEPTH = 2;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit        mreq;
    bit [3:0]  wstrb;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        iaok, daok, idok, ddok;
  } cyc_t;
  typedef struct packed { bit src; bit [31:0] addr; } pend_t;
  typedef struct packed { bit [31:0] rdata; bit store; } resp_t;

  cyc_t  cyc_q[$];
  pend_t pend_q[$];
  resp_t iresp_q[$], dresp_q[$];
  int    checks = 0;
  int    fails  = 0;

  // Requester and model state; src encoding 1 = data, 0 = inst.
  bit        i_act, d_act, d_drop;
  bit [31:0] i_addr, d_addr, d_wdata;
  bit [3:0]  d_wstrb;
  bit        held, held_src, rr_pref;
  bit [3:0]  held_wstrb;
  bit [31:0] held_addr, held_wdata;

  function automatic bit [31:0] mem_val(input bit [31:0] a);
    return a ^ 32'h1e80_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue_inst(input bit [31:0] a);
    i_act = 1'b1; i_addr = a;
  endtask

  task automatic issue_data(input bit [3:0] s, input bit [31:0] a, input bit [31:0] w);
    d_act = 1'b1; d_wstrb = s; d_addr = a; d_wdata = w;
  endtask

  task automatic cycle(input bit rst, input bit mao, input bit want_resp, input bit spurious);
    cyc_t e;
    bit ir, dr, src, any, accept, resp;
    @(posedge clk); #1;
    ir = i_act;
    dr = d_act && !d_drop;
    reset       = rst;
    inst_req    = ir;   inst_addr  = i_addr;
    data_req    = dr;   data_wstrb = d_wstrb; data_addr = d_addr; data_wdata = d_wdata;
    mem_addr_ok = mao;
    resp        = !rst && want_resp && (pend_q.size() > 0);
    mem_data_ok = resp || (spurious && pend_q.size() == 0);
    mem_rdata   = resp ? mem_val(pend_q[0].addr) : $urandom;
    e = '0;
    if (rst) begin
      pend_q.delete(); iresp_q.delete(); dresp_q.delete();
      held = 1'b0; rr_pref = 1'b1;
      cyc_q.push_back(e);
      return;
    end
    if (held) begin
      any = 1'b1; src = held_src;
      e.wstrb = held_wstrb; e.addr = held_addr; e.wdata = held_wdata;
    end else begin
      any = ir || dr;
      src = (ir && dr) ? (RR ? rr_pref : 1'b1) : dr;
      if (src) begin
        e.wstrb = d_wstrb; e.addr = d_addr; e.wdata = d_wdata;
      end else begin
        e.wstrb = 4'b0; e.addr = i_addr; e.wdata = 32'b0;
      end
    end
    e.mreq = any && (held || pend_q.size() < DEPTH);
    accept = e.mreq && mao;
    e.iaok = accept && !src;
    e.daok = accept && src;
    e.idok = resp && !pend_q[0].src;
    e.ddok = resp && pend_q[0].src;
    cyc_q.push_back(e);
    if (resp) void'(pend_q.pop_front());
    if (accept) begin
      pend_q.push_back('{src: src, addr: e.addr});
      if (src) begin
        dresp_q.push_back('{rdata: mem_val(e.addr), store: (e.wstrb != 4'b0)});
        d_act = 1'b0; d_drop = 1'b0;
      end else begin
        iresp_q.push_back('{rdata: mem_val(e.addr), store: 1'b0});
        i_act = 1'b0;
      end
      rr_pref = !src;
    end
    held = e.mreq && !mao;
    if (held) begin
      held_src = src; held_wstrb = e.wstrb; held_addr = e.addr; held_wdata = e.wdata;
    end
  endtask

  // Monitor: per-cycle handshake checks, plus response data popped whenever a data_ok appears.
  initial begin
    cyc_t  e;
    resp_t r;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("mem_req", mem_req, e.mreq);
        chk("inst_addr_ok", inst_addr_ok, e.iaok);
        chk("data_addr_ok", data_addr_ok, e.daok);
        chk("inst_data_ok", inst_data_ok, e.idok);
        chk("data_data_ok", data_data_ok, e.ddok);
        if (e.mreq) begin
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wstrb", mem_wstrb, e.wstrb);
          chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (inst_data_ok === 1'b1) begin
        if (iresp_q.size() == 0) chk("inst_resp_expected", 1, 0);
        else begin
          r = iresp_q.pop_front();
          chk("inst_rdata", inst_rdata, r.rdata);
        end
      end
      if (data_data_ok === 1'b1) begin
        if (dresp_q.size() == 0) chk("data_resp_expected", 1, 0);
        else begin
          r = dresp_q.pop_front();
          if (!r.store) chk("data_rdata", data_rdata, r.rdata);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    inst_addr = '0; data_addr = '0; data_wstrb = '0; data_wdata = '0; mem_rdata = '0;
    i_act = 0; d_act = 0; d_drop = 0; held = 0; rr_pref = 1;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;

    // Reset with both requests and stray responses present: everything must read 0.
    issue_inst(32'h1c00_0100); issue_data(4'b0, 32'h1c00_0200, 32'h0);
    cycle(1, 1, 0, 1); cycle(1, 1, 0, 1);
    i_act = 0; d_act = 0;
    cycle(0, 0, 0, 1);

    // Lone fetch, response two cycles later.
    issue_inst(32'h1c00_0000);
    cycle(0, 1, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 1, 0);

    // Simultaneous requests: data first, inst next cycle, responses in order.
    issue_inst(32'h1c00_0004); issue_data(4'b0, 32'h1c00_4000, 32'h0);
    cycle(0, 1, 0, 0); cycle(0, 1, 1, 0); cycle(0, 0, 1, 0);

    // Lock: addr_ok withheld, data_req withdrawn and inst_req raised; grant stays data.
    issue_data(4'b0, 32'h1c00_4010, 32'h0);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    d_drop = 1'b1; issue_inst(32'h1c00_0008);
    cycle(0, 0, 0, 0); cycle(0, 1, 0, 0); cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);

    // Full tag FIFO stalls the third request until one response drains.
    issue_inst(32'h1c00_000c); cycle(0, 1, 0, 0);
    issue_data(4'b0, 32'h1c00_4020, 32'h0); cycle(0, 1, 0, 0);
    issue_inst(32'h1c00_0010); cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0); cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0); cycle(0, 0, 1, 0);

    // Store pass-through.
    issue_data(4'b0011, 32'h1c00_8000, 32'hdead_beef);
    cycle(0, 1, 0, 0); cycle(0, 0, 1, 0);

    // Both requesters held for six cycles.
    for (int k = 0; k < 6; k++) begin
      if (!i_act) issue_inst(32'h1c00_1000 + 32'(k * 4));
      if (!d_act) issue_data(4'b0, 32'h1c00_5000 + 32'(k * 4), 32'h0);
      cycle(0, 1, 1, 0);
    end
    for (int k = 0; k < 20 && (i_act || d_act || pend_q.size() > 0); k++) cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 1);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      if (!i_act && $urandom_range(2) == 0) issue_inst($urandom & 32'hffff_fffc);
      if (!d_act && $urandom_range(2) == 0)
        issue_data(($urandom_range(1) == 0) ? 4'b0 : 4'($urandom_range(15, 1)), $urandom, $urandom);
      cycle(0, $urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(7) == 0);
    end

    // Reset mid-transaction discards tags; later stray responses are ignored.
    issue_inst(32'h1c00_2000); issue_data(4'b0, 32'h1c00_6000, 32'h0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    i_act = 0; d_act = 0; d_drop = 0;
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);

    issue_inst(32'h1c00_0000);
    for (int k = 0; k < 10 && (i_act || pend_q.size() > 0); k++) cycle(0, 1, 1, 0);

    @(negedge clk); @(negedge clk);
    chk("scoreboard_drained", 32'(iresp_q.size() + dresp_q.size() + cyc_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
